// File: rtl/resonator_pkg.sv
// Shared status codes and FSM encodings for the resonator factor-extraction path.
package resonator_pkg;

    typedef enum logic [1:0] {
        STATUS_OK         = 2'b00,
        STATUS_ODD_PERIOD = 2'b01,
        STATUS_TRIVIAL    = 2'b10,
        STATUS_ABORT      = 2'b11
    } fx_status_e;

    typedef enum logic [2:0] {
        FX_IDLE  = 3'd0,
        FX_POW   = 3'd1,
        FX_GCD_P = 3'd2,
        FX_GCD_Q = 3'd3,
        FX_DONE  = 3'd4
    } fx_state_e;

    // Extra ledger bits beyond the operand width.
    localparam int MU_EXTRA_BITS = 4;

endpackage

// File: rtl/gcd_engine.sv
// Subtractive GCD, one subtraction per cycle; start reloads even while busy.
// Gives up with timeout_o once 2^WIDTH busy cycles pass without converging.
module gcd_engine
    import resonator_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             timeout_o,
    output logic [WIDTH-1:0] result_o
);
    localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_W  = WIDTH'(1);

    logic             busy_q;
    logic [WIDTH-1:0] a_q, b_q, cnt_q;
    logic             term_s, last_s;

    // Termination and bound detection from the current operand pair.
    always_comb begin
        term_s    = (a_q == b_q) || (a_q == ZERO_W) || (b_q == ZERO_W);
        last_s    = (cnt_q == {WIDTH{1'b1}});
        done_o    = busy_q && (term_s || last_s);
        timeout_o = busy_q && !term_s && last_s;
        result_o  = (a_q == ZERO_W) ? b_q : a_q;
        busy_o    = busy_q;
    end

    // Operand load and one subtraction step per busy cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= 1'b0;
            a_q    <= ZERO_W;
            b_q    <= ZERO_W;
            cnt_q  <= ZERO_W;
        end else if (start_i) begin
            busy_q <= 1'b1;
            a_q    <= a_i;
            b_q    <= b_i;
            cnt_q  <= ZERO_W;
        end else if (busy_q) begin
            if (term_s || last_s) begin
                busy_q <= 1'b0;
            end else begin
                if (a_q > b_q) begin
                    a_q <= a_q - b_q;
                end else begin
                    b_q <= b_q - a_q;
                end
                cnt_q <= cnt_q + ONE_W;
            end
        end else begin
            busy_q <= 1'b0;
        end
    end

endmodule

// File: rtl/factor_extractor.sv
// Turns a period r of a mod N into factors gcd(a^(r/2) -/+ 1, N).
// Busy-cycle ledger on mu_cycles only when THIELE_FX_MU_LEDGER_EN is defined.
module factor_extractor
    import resonator_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [WIDTH-1:0]                modulus,
    input  logic [WIDTH-1:0]                base,
    input  logic [WIDTH-1:0]                period,
    input  logic                            in_stuck,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [WIDTH-1:0]                factor_p,
    output logic [WIDTH-1:0]                factor_q,
    output logic [1:0]                      status,
    output logic [WIDTH+MU_EXTRA_BITS-1:0]  mu_cycles
);
    localparam int               CW       = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);
    localparam logic [CW-1:0]    ONE_C    = CW'(1);
    localparam logic [CW-1:0]    LAST_POW = CW'(WIDTH - 1);

    fx_state_e        state_q;
    fx_status_e       status_q;
    logic             in_ready_q, out_valid_q;
    logic [WIDTH-1:0] n_q, base_q, acc_q, exp_q, p_q, factor_p_q, factor_q_q;
    logic [CW-1:0]    pow_cnt_q;

    logic [2*WIDTH-1:0] n_wide_s, acc_prod_s, base_prod_s;
    logic [WIDTH-1:0]   acc_next_s, base_next_s, x_dec_s, x_inc_s, gcd_a_s, gcd_result_s;
    logic               pow_last_s, trivial_s;
    logic               gcd_start_s, gcd_busy_s, gcd_done_s, gcd_timeout_s;

    // Square-and-multiply step at double width; x-1 and x+1 are taken mod N.
    always_comb begin
        n_wide_s    = {{WIDTH{1'b0}}, n_q};
        acc_prod_s  = {{WIDTH{1'b0}}, acc_q} * {{WIDTH{1'b0}}, base_q};
        base_prod_s = {{WIDTH{1'b0}}, base_q} * {{WIDTH{1'b0}}, base_q};
        acc_next_s  = exp_q[0] ? WIDTH'(acc_prod_s % n_wide_s) : acc_q;
        base_next_s = WIDTH'(base_prod_s % n_wide_s);
        pow_last_s  = (pow_cnt_q == LAST_POW);
        trivial_s   = (acc_next_s == ONE_W) || (acc_next_s == n_q - ONE_W);
        x_dec_s     = (acc_next_s == ZERO_W) ? n_q - ONE_W : acc_next_s - ONE_W;
        x_inc_s     = (acc_q + ONE_W == n_q) ? ZERO_W : acc_q + ONE_W;
    end

    // One engine serves both GCDs; it is started on the edge entering each GCD state.
    always_comb begin
        gcd_start_s = 1'b0;
        gcd_a_s     = x_dec_s;
        if (state_q == FX_POW && pow_last_s && !trivial_s) begin
            gcd_start_s = 1'b1;
        end else if (state_q == FX_GCD_P && gcd_done_s && !gcd_timeout_s) begin
            gcd_start_s = 1'b1;
            gcd_a_s     = x_inc_s;
        end else begin
            gcd_start_s = 1'b0;
        end
    end

    gcd_engine #(.WIDTH(WIDTH)) u_gcd (
        .clk       (clk),
        .reset     (reset),
        .start_i   (gcd_start_s),
        .a_i       (gcd_a_s),
        .b_i       (n_q),
        .busy_o    (gcd_busy_s),
        .done_o    (gcd_done_s),
        .timeout_o (gcd_timeout_s),
        .result_o  (gcd_result_s)
    );

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= FX_IDLE;
            status_q    <= STATUS_OK;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            n_q         <= ZERO_W;
            base_q      <= ZERO_W;
            acc_q       <= ZERO_W;
            exp_q       <= ZERO_W;
            p_q         <= ZERO_W;
            factor_p_q  <= ZERO_W;
            factor_q_q  <= ZERO_W;
            pow_cnt_q   <= {CW{1'b0}};
        end else begin
            case (state_q)
                FX_IDLE: begin
                    if (in_valid) begin
                        n_q        <= modulus;
                        base_q     <= base;
                        acc_q      <= ONE_W;
                        exp_q      <= period >> 1;
                        pow_cnt_q  <= {CW{1'b0}};
                        in_ready_q <= 1'b0;
                        factor_p_q <= ZERO_W;
                        factor_q_q <= ZERO_W;
                        if (in_stuck || period == ZERO_W || modulus <= ONE_W) begin
                            status_q    <= STATUS_ABORT;
                            out_valid_q <= 1'b1;
                            state_q     <= FX_DONE;
                        end else if (period[0]) begin
                            status_q    <= STATUS_ODD_PERIOD;
                            out_valid_q <= 1'b1;
                            state_q     <= FX_DONE;
                        end else begin
                            state_q <= FX_POW;
                        end
                    end
                end
                FX_POW: begin
                    acc_q     <= acc_next_s;
                    base_q    <= base_next_s;
                    exp_q     <= exp_q >> 1;
                    pow_cnt_q <= pow_cnt_q + ONE_C;
                    if (pow_last_s) begin
                        if (trivial_s) begin
                            status_q    <= STATUS_TRIVIAL;
                            out_valid_q <= 1'b1;
                            state_q     <= FX_DONE;
                        end else begin
                            state_q <= FX_GCD_P;
                        end
                    end
                end
                FX_GCD_P: begin
                    if (gcd_timeout_s || !gcd_busy_s) begin
                        status_q    <= STATUS_ABORT;
                        out_valid_q <= 1'b1;
                        state_q     <= FX_DONE;
                    end else if (gcd_done_s) begin
                        p_q     <= gcd_result_s;
                        state_q <= FX_GCD_Q;
                    end
                end
                FX_GCD_Q: begin
                    if (gcd_timeout_s || !gcd_busy_s) begin
                        status_q    <= STATUS_ABORT;
                        out_valid_q <= 1'b1;
                        state_q     <= FX_DONE;
                    end else if (gcd_done_s) begin
                        out_valid_q <= 1'b1;
                        state_q     <= FX_DONE;
                        if (p_q == ONE_W || p_q == n_q) begin
                            status_q <= STATUS_TRIVIAL;
                        end else begin
                            status_q   <= STATUS_OK;
                            factor_p_q <= p_q;
                            factor_q_q <= gcd_result_s;
                        end
                    end
                end
                FX_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= FX_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= FX_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign factor_p  = factor_p_q;
    assign factor_q  = factor_q_q;
    assign status    = status_q;

`ifdef THIELE_FX_MU_LEDGER_EN
    logic [WIDTH+MU_EXTRA_BITS-1:0] mu_q;

    // Saturating count of non-IDLE cycles, restarted by every accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            mu_q <= {(WIDTH+MU_EXTRA_BITS){1'b0}};
        end else if (state_q == FX_IDLE && in_valid) begin
            mu_q <= {(WIDTH+MU_EXTRA_BITS){1'b0}};
        end else if (state_q != FX_IDLE && mu_q != {(WIDTH+MU_EXTRA_BITS){1'b1}}) begin
            mu_q <= mu_q + (WIDTH+MU_EXTRA_BITS)'(1);
        end else begin
            mu_q <= mu_q;
        end
    end

    assign mu_cycles = mu_q;
`else
    assign mu_cycles = {(WIDTH+MU_EXTRA_BITS){1'b0}};
`endif

endmodule

// File: doc/factor_extractor.md
FACTOR_EXTRACTOR -- requirements
Module: factor_extractor

Interface
REQ-001 SHALL have parameter WIDTH, default 4: operand width, matching the upstream period finder.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1 bit: upstream result valid, driven from the period finder's done.
REQ-005 SHALL have port in_ready, output, 1 bit: block can accept a job.
REQ-006 SHALL have ports modulus, base and period, inputs, WIDTH bits each: N, a and r from upstream.
REQ-007 SHALL have port in_stuck, input, 1 bit: upstream stuck flag.
REQ-008 SHALL have port out_valid, output, 1 bit: result valid.
REQ-009 SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-010 SHALL have ports factor_p and factor_q, outputs, WIDTH bits each: the extracted factors.
REQ-011 SHALL have port status, output, 2 bits: 00 OK, 01 ODD_PERIOD, 10 TRIVIAL, 11 ABORT.
REQ-012 SHALL have port mu_cycles, output, WIDTH+4 bits: busy-cycle ledger.

Function
REQ-013 SHALL use FSM states IDLE, POW, GCD_P, GCD_Q, DONE.
REQ-014 SHALL drive in_ready=1 only in IDLE; accept when in_valid && in_ready, latching N, a, r and in_stuck.
REQ-015 SHALL ignore in_valid outside IDLE; the input is not consumed and no state changes.
REQ-016 SHALL go to DONE with ABORT on accept if in_stuck=1, r=0 or N<2, with factors=0.
REQ-017 SHALL otherwise go to DONE with ODD_PERIOD on accept if r is odd, with factors=0.
REQ-018 SHALL otherwise enter POW with exponent e=r>>1 and accumulator=1.
REQ-019 SHALL in POW process one exponent bit per cycle, LSB first, for exactly WIDTH cycles.
REQ-020 SHALL compute POW products at full 2*WIDTH width, reduced mod N, yielding x=a^e mod N.
REQ-021 SHALL go to DONE with TRIVIAL after POW if x==1 or x==N-1.
REQ-022 SHALL otherwise enter GCD_P computing p=gcd(x-1,N), then GCD_Q computing q=gcd((x+1) mod N,N).
REQ-023 SHALL run each GCD subtractively, one subtraction per cycle, ending when operands are equal or one is zero.
REQ-024 SHALL bound each GCD at 2^WIDTH cycles and force ABORT if the bound is exceeded.
REQ-025 SHALL report TRIVIAL if p==1 or p==N; otherwise OK with factor_p=p and factor_q=q.
REQ-026 SHALL in DONE hold out_valid=1 with stable outputs until out_ready=1, then go to IDLE next cycle.
REQ-027 SHALL assert out_valid exactly 1 cycle after accept for ABORT/ODD_PERIOD results.
REQ-028 SHALL bound normal latency at ≤ 1+WIDTH+2*2^WIDTH cycles.
REQ-029 SHALL make mu_cycles count cycles spent outside IDLE, saturating at all-ones, cleared on each accept.

Reset
REQ-030 SHALL on reset go to IDLE and drive in_ready=1, out_valid=0, factor_p=0, factor_q=0, status=00, mu_cycles=0.
REQ-031 SHALL on reset mid-operation (any state) discard the job and emit no out_valid.

Configuration
REQ-032 SHALL implement the mu_cycles ledger (REQ-029) only when THIELE_FX_MU_LEDGER_EN is defined.
REQ-033 SHALL keep the mu_cycles port when the macro is undefined, tied to 0, with all other behaviour identical.

Structure
REQ-034 SHALL place the status codes and FSM state encodings in shared package resonator_pkg.
REQ-035 SHALL implement the subtractive GCD as sub-module gcd_engine (start/busy/done handshake, one step per cycle), instantiated once and reused for GCD_P and GCD_Q.

Verification
REQ-036 SHALL cover: N=15, a=7, r=4 -> x=4, OK, p=3, q=5.
REQ-037 SHALL cover: N=15, a=14, r=2 -> x=14, TRIVIAL, factors=0.
REQ-038 SHALL cover: N=7, a=2, r=3 -> ODD_PERIOD, out_valid 1 cycle after accept.
REQ-039 SHALL cover: in_stuck=1 with any operands -> ABORT; then N=1 -> ABORT.
REQ-040 SHALL cover: N=15, a=2, r=4 with out_ready held 0 for 5 cycles -> outputs stable, in_ready=0, extra in_valid ignored; out_ready=1 -> IDLE next cycle.
REQ-041 SHALL cover: reset asserted during GCD_P -> IDLE next cycle, all outputs at reset values, no out_valid.
